// File: rtl/burst_ram_arbiter.sv
// Two-port burst arbiter sharing one BurstRAM between the I-cache (port 0) and the D-cache (port 1).
// Optional feature: define ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking (default is fixed priority to port 0).
module burst_ram_arbiter #(
  parameter int RAM_DEPTH_BITWIDTH      = 4,
  parameter int RAM_BURST_DATA_BITWIDTH = 64,
  parameter int RAM_BURST_DATA_COUNT    = 4
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,

  input  logic                                 i_p0_cmd,
  input  logic                                 i_p0_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]        i_p0_addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   i_p0_wr_data,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] i_p0_data_mask,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   o_p0_rd_data,
  output logic                                 o_p0_rd_data_valid,
  output logic                                 o_p0_ack,
  output logic                                 o_p0_gnt,

  input  logic                                 i_p1_cmd,
  input  logic                                 i_p1_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]        i_p1_addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   i_p1_wr_data,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] i_p1_data_mask,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   o_p1_rd_data,
  output logic                                 o_p1_rd_data_valid,
  output logic                                 o_p1_ack,
  output logic                                 o_p1_gnt,

  output logic                                 o_br_cmd,
  output logic                                 o_br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0]        o_br_addr,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   o_br_wr_data,
  output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] o_br_data_mask,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   i_br_rd_data,
  input  logic                                 i_br_rd_data_valid,
  input  logic                                 i_br_busy
);

  localparam int CW = $clog2(RAM_BURST_DATA_COUNT);
  localparam logic [CW-1:0] LAST_BEAT = CW'(RAM_BURST_DATA_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [CW-1:0]                 r_cnt;
  logic [CW-1:0]                 w_cnt_nxt;
  logic                          r_gnt0;
  logic                          r_gnt1;
  logic                          w_gnt0_nxt;
  logic                          w_gnt1_nxt;
  logic                          r_ack0;
  logic                          r_ack1;
  logic                          w_ack0_nxt;
  logic                          w_ack1_nxt;
  logic                          r_br_cmd_en;
  logic                          w_br_cmd_en_nxt;
  logic                          r_br_cmd;
  logic                          w_br_cmd_nxt;
  logic [RAM_DEPTH_BITWIDTH-1:0] r_br_addr;
  logic [RAM_DEPTH_BITWIDTH-1:0] w_br_addr_nxt;

  logic                          w_req_any;
  logic                          w_pick1;
  logic                          w_issue;
  logic                          w_win_cmd;
  logic [RAM_DEPTH_BITWIDTH-1:0] w_win_addr;

  assign w_req_any = i_p0_cmd_en | i_p1_cmd_en;

`ifdef ARBITER_ROUND_ROBIN_EN
  // r_last1 remembers which port won the previous ack; the other port wins a tie.
  logic r_last1;

  assign w_pick1 = i_p1_cmd_en & (~i_p0_cmd_en | ~r_last1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last1 <= 1'b1;
    end else if (w_issue) begin
      r_last1 <= w_pick1;
    end
  end
`else
  assign w_pick1 = i_p1_cmd_en & ~i_p0_cmd_en;
`endif

  assign w_issue    = (r_state == S_IDLE) & ~i_br_busy & w_req_any;
  assign w_win_cmd  = w_pick1 ? i_p1_cmd  : i_p0_cmd;
  assign w_win_addr = w_pick1 ? i_p1_addr : i_p0_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_br_cmd_en <= 1'b0;
      r_br_cmd    <= 1'b0;
      r_br_addr   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gnt0      <= w_gnt0_nxt;
      r_gnt1      <= w_gnt1_nxt;
      r_ack0      <= w_ack0_nxt;
      r_ack1      <= w_ack1_nxt;
      r_br_cmd_en <= w_br_cmd_en_nxt;
      r_br_cmd    <= w_br_cmd_nxt;
      r_br_addr   <= w_br_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_gnt0_nxt      = r_gnt0;
    w_gnt1_nxt      = r_gnt1;
    w_ack0_nxt      = 1'b0;
    w_ack1_nxt      = 1'b0;
    w_br_cmd_en_nxt = 1'b0;
    w_br_cmd_nxt    = r_br_cmd;
    w_br_addr_nxt   = r_br_addr;

    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_br_cmd_en_nxt = 1'b1;
          w_br_cmd_nxt    = w_win_cmd;
          w_br_addr_nxt   = w_win_addr;
          w_ack0_nxt      = ~w_pick1;
          w_ack1_nxt      = w_pick1;
          w_gnt0_nxt      = ~w_pick1;
          w_gnt1_nxt      = w_pick1;
          w_cnt_nxt       = '0;
          w_state_nxt     = w_win_cmd ? S_WRITE : S_READ;
        end
      end

      S_READ: begin
        if (i_br_rd_data_valid) begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == LAST_BEAT) begin
            w_state_nxt = S_IDLE;
            w_gnt0_nxt  = 1'b0;
            w_gnt1_nxt  = 1'b0;
          end
        end
      end

      // Write beats are counted by cycle: the requester streams one beat per cycle from the ack.
      S_WRITE: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == LAST_BEAT) begin
          w_state_nxt = S_IDLE;
          w_gnt0_nxt  = 1'b0;
          w_gnt1_nxt  = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_gnt0_nxt  = 1'b0;
        w_gnt1_nxt  = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_br_cmd_en = r_br_cmd_en;
  assign o_br_cmd    = r_br_cmd;
  assign o_br_addr   = r_br_addr;
  assign o_p0_ack    = r_ack0;
  assign o_p1_ack    = r_ack1;
  assign o_p0_gnt    = r_gnt0;
  assign o_p1_gnt    = r_gnt1;

  assign o_br_wr_data   = r_gnt0 ? i_p0_wr_data   : (r_gnt1 ? i_p1_wr_data   : '0);
  assign o_br_data_mask = r_gnt0 ? i_p0_data_mask : (r_gnt1 ? i_p1_data_mask : '0);

  assign o_p0_rd_data       = i_br_rd_data;
  assign o_p1_rd_data       = i_br_rd_data;
  assign o_p0_rd_data_valid = i_br_rd_data_valid & (r_state == S_READ) & r_gnt0;
  assign o_p1_rd_data_valid = i_br_rd_data_valid & (r_state == S_READ) & r_gnt1;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed self-checking bench for burst_ram_arbiter; expectations follow the build's ARBITER_ROUND_ROBIN_EN setting.
module tb_burst_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 64;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p0_cmd = 1'b0, p0_cmd_en = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wr_data = '0;
  logic [MW-1:0] p0_data_mask = '0;
  logic [DW-1:0] p0_rd_data;
  logic          p0_rd_data_valid, p0_ack, p0_gnt;
  logic          p1_cmd = 1'b0, p1_cmd_en = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wr_data = '0;
  logic [MW-1:0] p1_data_mask = '0;
  logic [DW-1:0] p1_rd_data;
  logic          p1_rd_data_valid, p1_ack, p1_gnt;
  logic          br_cmd, br_cmd_en;
  logic [AW-1:0] br_addr;
  logic [DW-1:0] br_wr_data;
  logic [MW-1:0] br_data_mask;
  logic [DW-1:0] br_rd_data = '0;
  logic          br_rd_data_valid = 1'b0;
  logic          br_busy = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  burst_ram_arbiter #(
    .RAM_DEPTH_BITWIDTH(AW), .RAM_BURST_DATA_BITWIDTH(DW), .RAM_BURST_DATA_COUNT(4)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_p0_cmd(p0_cmd), .i_p0_cmd_en(p0_cmd_en), .i_p0_addr(p0_addr),
    .i_p0_wr_data(p0_wr_data), .i_p0_data_mask(p0_data_mask),
    .o_p0_rd_data(p0_rd_data), .o_p0_rd_data_valid(p0_rd_data_valid),
    .o_p0_ack(p0_ack), .o_p0_gnt(p0_gnt),
    .i_p1_cmd(p1_cmd), .i_p1_cmd_en(p1_cmd_en), .i_p1_addr(p1_addr),
    .i_p1_wr_data(p1_wr_data), .i_p1_data_mask(p1_data_mask),
    .o_p1_rd_data(p1_rd_data), .o_p1_rd_data_valid(p1_rd_data_valid),
    .o_p1_ack(p1_ack), .o_p1_gnt(p1_gnt),
    .o_br_cmd(br_cmd), .o_br_cmd_en(br_cmd_en), .o_br_addr(br_addr),
    .o_br_wr_data(br_wr_data), .o_br_data_mask(br_data_mask),
    .i_br_rd_data(br_rd_data), .i_br_rd_data_valid(br_rd_data_valid), .i_br_busy(br_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if ({br_cmd_en, br_cmd, p0_ack, p1_ack, p0_gnt, p1_gnt} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl got %b want 000000", {br_cmd_en, br_cmd, p0_ack, p1_ack, p0_gnt, p1_gnt});
    end
    n_vec++;
    if (br_addr !== 4'h0) begin n_err++; $display("FAIL reset_addr got %0h want 0", br_addr); end
    n_vec++;
    if (br_wr_data !== 64'h0 || br_data_mask !== 8'h0) begin
      n_err++; $display("FAIL reset_wr got %0h/%0h want 0/0", br_wr_data, br_data_mask);
    end
  endtask

  task automatic test_single_read();
    int cmd_en_cycles = 0;
    p0_cmd = 1'b0; p0_addr = 4'd5; p0_cmd_en = 1'b1;
    tick();
    n_vec++;
    if ({br_cmd_en, br_cmd, p0_ack, p0_gnt, p1_ack, p1_gnt} !== 6'b101100) begin
      n_err++;
      $display("FAIL rd_issue got %b want 101100", {br_cmd_en, br_cmd, p0_ack, p0_gnt, p1_ack, p1_gnt});
    end
    n_vec++;
    if (br_addr !== 4'd5) begin n_err++; $display("FAIL rd_addr got %0d want 5", br_addr); end
    if (br_cmd_en) cmd_en_cycles++;
    p0_cmd_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (br_cmd_en) cmd_en_cycles++;
      br_rd_data_valid = 1'b1;
      br_rd_data = 64'hA0 + 64'(k);
      #1;
      n_vec++;
      if (p0_rd_data_valid !== 1'b1 || p1_rd_data_valid !== 1'b0 || p0_rd_data !== 64'hA0 + 64'(k)) begin
        n_err++;
        $display("FAIL rd_beat%0d got v0=%b v1=%b d=%0h want v0=1 v1=0 d=%0h",
                 k, p0_rd_data_valid, p1_rd_data_valid, p0_rd_data, 64'hA0 + 64'(k));
      end
    end
    tick();
    // A stray valid while idle must not reach either port.
    #1;
    n_vec++;
    if (p0_rd_data_valid !== 1'b0 || p1_rd_data_valid !== 1'b0) begin
      n_err++; $display("FAIL rd_idle_valid got %b%b want 00", p0_rd_data_valid, p1_rd_data_valid);
    end
    br_rd_data_valid = 1'b0;
    n_vec++;
    if (p0_gnt !== 1'b0) begin n_err++; $display("FAIL rd_gnt_drop got %b want 0", p0_gnt); end
    n_vec++;
    if (cmd_en_cycles != 1) begin n_err++; $display("FAIL rd_cmd_en_cycles got %0d want 1", cmd_en_cycles); end
    tick();
  endtask

  task automatic test_single_write();
    p1_cmd = 1'b1; p1_addr = 4'd3; p1_wr_data = 64'h11; p1_data_mask = 8'hFF; p1_cmd_en = 1'b1;
    #1;
    n_vec++;
    if (br_data_mask !== 8'h00) begin n_err++; $display("FAIL wr_mask_pre got %0h want 0", br_data_mask); end
    tick();
    n_vec++;
    if ({br_cmd_en, br_cmd, p1_ack, p1_gnt, p0_ack, p0_gnt} !== 6'b111100 || br_addr !== 4'd3) begin
      n_err++;
      $display("FAIL wr_issue got %b addr %0d want 111100 addr 3",
               {br_cmd_en, br_cmd, p1_ack, p1_gnt, p0_ack, p0_gnt}, br_addr);
    end
    n_vec++;
    if (br_wr_data !== 64'h11 || br_data_mask !== 8'hFF) begin
      n_err++; $display("FAIL wr_beat0 got %0h/%0h want 11/ff", br_wr_data, br_data_mask);
    end
    p1_cmd_en = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      p1_wr_data = 64'h11 * 64'(k + 1);
      #1;
      n_vec++;
      if (br_wr_data !== 64'h11 * 64'(k + 1) || p1_gnt !== 1'b1) begin
        n_err++;
        $display("FAIL wr_beat%0d got %0h gnt %b want %0h gnt 1", k, br_wr_data, p1_gnt, 64'h11 * 64'(k + 1));
      end
    end
    tick();
    n_vec++;
    if (p1_gnt !== 1'b0 || br_data_mask !== 8'h00 || br_wr_data !== 64'h0 || br_cmd_en !== 1'b0) begin
      n_err++;
      $display("FAIL wr_end got gnt %b mask %0h data %0h en %b want 0 0 0 0", p1_gnt, br_data_mask, br_wr_data, br_cmd_en);
    end
    p1_data_mask = 8'h00; p1_wr_data = '0;
    tick();
  endtask

  task automatic test_simultaneous();
    p0_cmd = 1'b0; p0_addr = 4'd1; p0_cmd_en = 1'b1;
    p1_cmd = 1'b1; p1_addr = 4'd2; p1_wr_data = 64'hAA; p1_data_mask = 8'h0F; p1_cmd_en = 1'b1;
    tick();
    n_vec++;
    if (p0_ack !== 1'b1 || p1_ack !== 1'b0 || br_addr !== 4'd1 || br_cmd !== 1'b0) begin
      n_err++;
      $display("FAIL sim_first got ack %b%b addr %0d cmd %b want ack 10 addr 1 cmd 0", p0_ack, p1_ack, br_addr, br_cmd);
    end
    p0_cmd_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      br_rd_data_valid = 1'b1;
    end
    tick();
    br_rd_data_valid = 1'b0;
    n_vec++;
    if (p1_ack !== 1'b0 || br_cmd_en !== 1'b0 || p0_gnt !== 1'b0) begin
      n_err++; $display("FAIL sim_gap got ack1 %b en %b gnt0 %b want 0 0 0", p1_ack, br_cmd_en, p0_gnt);
    end
    tick();
    n_vec++;
    if (p1_ack !== 1'b1 || br_cmd_en !== 1'b1 || br_addr !== 4'd2 || br_cmd !== 1'b1 || br_wr_data !== 64'hAA) begin
      n_err++;
      $display("FAIL sim_second got ack1 %b en %b addr %0d cmd %b data %0h want 1 1 2 1 aa",
               p1_ack, br_cmd_en, br_addr, br_cmd, br_wr_data);
    end
    p1_cmd_en = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    n_vec++;
    if (p1_gnt !== 1'b0) begin n_err++; $display("FAIL sim_wr_end got gnt1 %b want 0", p1_gnt); end
    p1_data_mask = '0; p1_wr_data = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_win1;
    int n;
    logic win1;
`ifdef ARBITER_ROUND_ROBIN_EN
    exp_win1 = 4'b1010;
`else
    exp_win1 = 4'b0000;
`endif
    p0_cmd = 1'b0; p0_addr = 4'd4; p0_cmd_en = 1'b1;
    p1_cmd = 1'b0; p1_addr = 4'd8; p1_cmd_en = 1'b1;
    for (int b = 0; b < 4; b++) begin
      n = 0;
      while (!(p0_ack || p1_ack) && n < 10) begin tick(); n++; end
      n_vec++;
      if (n >= 10) begin
        n_err++; $display("FAIL rr_timeout burst %0d got no ack want ack", b);
      end
      win1 = p1_ack;
      n_vec++;
      if (win1 !== exp_win1[b]) begin
        n_err++; $display("FAIL rr_order burst %0d got port %0d want port %0d", b, win1, exp_win1[b]);
      end
      if (b == 3) begin p0_cmd_en = 1'b0; p1_cmd_en = 1'b0; end
      for (int k = 0; k < 4; k++) begin
        tick();
        br_rd_data_valid = 1'b1;
      end
      tick();
      br_rd_data_valid = 1'b0;
    end
    tick();
  endtask

  task automatic test_busy_holdoff();
    int early = 0;
    br_busy = 1'b1;
    p0_cmd = 1'b0; p0_addr = 4'd6; p0_cmd_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (br_cmd_en || p0_ack) early++;
    end
    n_vec++;
    if (early != 0) begin n_err++; $display("FAIL busy_hold got %0d issues want 0", early); end
    br_busy = 1'b0;
    tick();
    n_vec++;
    if (br_cmd_en !== 1'b1 || p0_ack !== 1'b1 || br_addr !== 4'd6) begin
      n_err++; $display("FAIL busy_release got en %b ack %b addr %0d want 1 1 6", br_cmd_en, p0_ack, br_addr);
    end
    p0_cmd_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      br_rd_data_valid = 1'b1;
    end
    tick();
    br_rd_data_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    p0_cmd = 1'b0; p0_addr = 4'd7; p0_cmd_en = 1'b1;
    tick();
    p0_cmd_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      br_rd_data_valid = 1'b1;
    end
    tick();
    br_rd_data_valid = 1'b0;
    rst = 1'b1;
    tick();
    n_vec++;
    if ({br_cmd_en, br_cmd, p0_ack, p1_ack, p0_gnt, p1_gnt} !== 6'b0 || br_addr !== 4'd0) begin
      n_err++;
      $display("FAIL rst_mid got %b addr %0d want 000000 addr 0",
               {br_cmd_en, br_cmd, p0_ack, p1_ack, p0_gnt, p1_gnt}, br_addr);
    end
    rst = 1'b0;
    p1_cmd = 1'b0; p1_addr = 4'd9; p1_cmd_en = 1'b1;
    tick();
    n_vec++;
    if (p1_ack !== 1'b1 || br_cmd_en !== 1'b1 || br_addr !== 4'd9) begin
      n_err++; $display("FAIL rst_reissue got ack %b en %b addr %0d want 1 1 9", p1_ack, br_cmd_en, br_addr);
    end
    p1_cmd_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      br_rd_data_valid = 1'b1;
      #1;
      n_vec++;
      if (p1_rd_data_valid !== 1'b1 || p0_rd_data_valid !== 1'b0) begin
        n_err++; $display("FAIL rst_rd_beat%0d got v1=%b v0=%b want 1 0", k, p1_rd_data_valid, p0_rd_data_valid);
      end
    end
    tick();
    br_rd_data_valid = 1'b0;
    n_vec++;
    if (p1_gnt !== 1'b0) begin n_err++; $display("FAIL rst_rd_end got gnt1 %b want 0", p1_gnt); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_simultaneous();
    test_round_robin();
    test_busy_holdoff();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
